// File: rtl/mac_cmd_sequencer_pkg.sv
// Shared definitions for the MAC command sequencer: command/status codes,
// 3-bit state encodings, default parameters and the state-to-command decode.
package mac_cmd_sequencer_pkg;

    // Command codes driven on I towards the MAC control FSM
    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_ACC = 2'b01;
    localparam logic [1:0] CMD_CLR = 2'b10;
    localparam logic [1:0] CMD_OUT = 2'b11;

    // Status code returned on O when the MAC result is available
    localparam logic [1:0] RES_VALID = 2'b10;

    // Sequencer state encodings
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CLR  = 3'd1;
    localparam logic [2:0] ST_ACC  = 3'd2;
    localparam logic [2:0] ST_OUT  = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam int unsigned DEF_LEN_W   = 8;
    localparam int unsigned DEF_TIMEOUT = 15;

    // Command presented while the sequencer sits in a given state
    function automatic logic [1:0] cmd_for_state(input logic [2:0] st);
        case (st)
            ST_CLR:  return CMD_CLR;
            ST_ACC:  return CMD_ACC;
            ST_OUT:  return CMD_OUT;
            default: return CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/mac_seq_counter.sv
// Loadable up-counter with synchronous clear, load and enable, plus an
// equality compare against a terminal value.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : synchronous clear (highest priority)
//   load       : load load_val
//   en         : increment by one
//   cmp_val    : terminal value for term_c
//   count      : registered count
//   term_c     : count == cmp_val (decoded from the register)
module mac_seq_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] cmp_val,
    output logic [W-1:0] count,
    output logic         term_c
);

    // Counter register: clear > load > increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign term_c = (count == cmp_val);

endmodule

// File: rtl/mac_cmd_sequencer.sv
// Command-issuing end of the MAC control interface. Accepts a job (LEN),
// issues CLR, LEN x ACC and OUT on I, waits for RES_VALID on O (bounded by
// TIMEOUT cycles) and signals completion with a one-cycle DONE pulse.
//   CLK, S      : clock, asynchronous active-low reset
//   START, LEN  : job request and length, sampled only in IDLE
//   ABORT       : synchronous cancel of the running job (no DONE)
//   O           : status from the MAC control FSM
//   I           : command to the MAC control FSM
//   ADDR        : operand index for the current ACC step
//   READY       : high in IDLE only
//   DONE, ERR   : completion pulse; ERR=1 flags a timeout, held until next START
module mac_cmd_sequencer
    import mac_cmd_sequencer_pkg::*;
#(
    parameter int unsigned LEN_W   = DEF_LEN_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             CLK,
    input  logic             S,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    input  logic             ABORT,
    input  logic [1:0]       O,
    output logic [1:0]       I,
    output logic [LEN_W-1:0] ADDR,
    output logic             READY,
    output logic             DONE,
    output logic             ERR
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [2:0]       state;
    logic [2:0]       nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] addr_last_c;
    logic             accept_c;
    logic             res_valid_c;
    logic             addr_term_c;
    logic             wait_term_c;
    logic             addr_clr_c;
    logic             addr_en_c;
    logic             wait_clr_c;
    logic             wait_load_c;
    logic             wait_en_c;
    logic [TW-1:0]    wait_cnt_unused;
    logic [1:0]       cmd_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;

    assign accept_c    = (state == ST_IDLE) && START;
    assign res_valid_c = (O == RES_VALID);
    assign addr_last_c = len_q - LEN_W'(1);

    // State register
    always_ff @(posedge CLK or negedge S) begin
        if (!S) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next state and counter controls; ABORT outranks every busy transition
    always_comb begin
        nxt = state;
        if (state == ST_IDLE) begin
            if (START) begin
                nxt = ST_CLR;
            end
        end else if (ABORT) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_CLR:  nxt = (len_q != '0) ? ST_ACC : ST_OUT;
                ST_ACC:  nxt = addr_term_c ? ST_OUT : ST_ACC;
                ST_OUT:  nxt = ST_WAIT;
                ST_WAIT: nxt = (res_valid_c || wait_term_c) ? ST_DONE : ST_WAIT;
                ST_DONE: nxt = ST_IDLE;
                default: nxt = ST_IDLE;
            endcase
        end

        // ADDR is 0 through CLR and the first ACC, then steps once per ACC
        addr_clr_c  = (nxt == ST_IDLE) || (nxt == ST_CLR);
        addr_en_c   = (state == ST_ACC) && (nxt == ST_ACC);
        // Wait counter reads 1 in the first WAIT cycle, so term hits on cycle TIMEOUT
        wait_clr_c  = (nxt == ST_IDLE);
        wait_load_c = (state == ST_OUT) && (nxt == ST_WAIT);
        wait_en_c   = (state == ST_WAIT) && (nxt == ST_WAIT);
    end

    // Registered outputs decoded from the next state, job length latch
    always_ff @(posedge CLK or negedge S) begin
        if (!S) begin
            len_q   <= '0;
            cmd_q   <= CMD_NOP;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                len_q <= LEN;
            end
            cmd_q   <= cmd_for_state(nxt);
            ready_q <= (nxt == ST_IDLE);
            done_q  <= (nxt == ST_DONE);
            // A result arriving on the timeout cycle still counts as success
            if (accept_c) begin
                err_q <= 1'b0;
            end else if ((state == ST_WAIT) && (nxt == ST_DONE)) begin
                err_q <= !res_valid_c;
            end
        end
    end

    // Operand index counter
    mac_seq_counter #(
        .W (LEN_W)
    ) u_addr_cnt (
        .clk      (CLK),
        .rst_n    (S),
        .clr      (addr_clr_c),
        .load     (1'b0),
        .load_val (LEN_W'(0)),
        .en       (addr_en_c),
        .cmp_val  (addr_last_c),
        .count    (ADDR),
        .term_c   (addr_term_c)
    );

    // WAIT-state timeout counter
    mac_seq_counter #(
        .W (TW)
    ) u_wait_cnt (
        .clk      (CLK),
        .rst_n    (S),
        .clr      (wait_clr_c),
        .load     (wait_load_c),
        .load_val (TW'(1)),
        .en       (wait_en_c),
        .cmp_val  (TW'(TIMEOUT)),
        .count    (wait_cnt_unused),
        .term_c   (wait_term_c)
    );

    assign I     = cmd_q;
    assign READY = ready_q;
    assign DONE  = done_q;
    assign ERR   = err_q;

endmodule
